// File: rtl/i3c_hci_queue_pkg.sv
// Shared types and constants for the I3C HCI queue slice.
package i3c_hci_pkg;

  localparam int unsigned I3CCSR_DATA_WIDTH = 32;
  localparam int unsigned CMD_QUEUE_DEPTH   = 64;
  localparam int unsigned TX_QUEUE_DEPTH    = 64;

  typedef logic [I3CCSR_DATA_WIDTH-1:0] hci_queue_entry_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned hci_occ_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/i3c_hci_queue_if.sv
// Queue-port bundle between the CSR block (master) and the queue (slave).
interface i3c_hci_queue_if #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned THLD_WIDTH = 8
);

  localparam int unsigned OCC_WIDTH = i3c_hci_pkg::hci_occ_width(DEPTH);

  logic                  wr_valid_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic                  wr_ready_o;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [DATA_WIDTH-1:0] rd_data_o;
  logic [THLD_WIDTH-1:0] thld_i;
  logic                  thld_trig_o;
  logic [OCC_WIDTH-1:0]  occupancy_o;
  logic                  empty_o;
  logic                  full_o;
  logic                  overflow_o;
  logic                  overflow_clr_i;
  logic                  flush_i;

  modport master (
    output wr_valid_i, wr_data_i, rd_ready_i, thld_i, overflow_clr_i, flush_i,
    input  wr_ready_o, rd_valid_o, rd_data_o, thld_trig_o, occupancy_o, empty_o, full_o,
           overflow_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, rd_ready_i, thld_i, overflow_clr_i, flush_i,
    output wr_ready_o, rd_valid_o, rd_data_o, thld_trig_o, occupancy_o, empty_o, full_o,
           overflow_o
  );

endinterface

// File: rtl/i3c_hci_queue_thld.sv
// Threshold clamp and compare. OCC_SENSE=0 triggers on free space, 1 on fill level.
module i3c_hci_queue_thld
  import i3c_hci_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned THLD_WIDTH = 8,
  parameter bit          OCC_SENSE  = 1'b0
) (
  input  logic [hci_occ_width(DEPTH)-1:0] occupancy_i,
  input  logic [THLD_WIDTH-1:0]           thld_i,
  output logic                            trig_o
);

  localparam int unsigned OW = hci_occ_width(DEPTH);
  // One extra bit so DEPTH - occupancy never truncates.
  localparam int unsigned CW = OW + 1;
  // Clamp compare runs wide enough for both the raw threshold and DEPTH.
  localparam int unsigned WW = (THLD_WIDTH > CW) ? THLD_WIDTH : CW;

  logic [WW-1:0] thld_w;
  logic [WW-1:0] depth_w;
  logic [WW-1:0] eff_w;
  logic [CW-1:0] eff_thld;
  logic [CW-1:0] occ_c;
  logic [CW-1:0] free_c;

  // Clamp threshold to 1..DEPTH, then compare against free space or fill level.
  always_comb begin
    thld_w  = WW'(thld_i);
    depth_w = WW'(DEPTH);
    if (thld_w == '0) begin
      eff_w = WW'(1);
    end else if (thld_w > depth_w) begin
      eff_w = depth_w;
    end else begin
      eff_w = thld_w;
    end
    eff_thld = CW'(eff_w);
    occ_c    = CW'(occupancy_i);
    free_c   = CW'(DEPTH) - occ_c;
    trig_o   = OCC_SENSE ? (occ_c >= eff_thld) : (free_c >= eff_thld);
  end

endmodule

// File: rtl/i3c_hci_queue.sv
// Command/TX-data FIFO between the CSR queue-port registers and the controller datapath.
module i3c_hci_queue
  import i3c_hci_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned THLD_WIDTH = 8
) (
  input  logic hclk_i,
  input  logic hreset_n_i,
  i3c_hci_queue_if.slave q
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Pointer MSB distinguishes full from empty.
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = hci_occ_width(DEPTH);

  if (!(DEPTH >= 2 && DEPTH <= 256 && (DEPTH & (DEPTH - 1)) == 0)) begin : g_depth_check
    $error("i3c_hci_queue: DEPTH must be a power of two in 2..256");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  overflow_q, overflow_d;
  logic [PW-1:0]         occ;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;

  // Status and handshake decode from the registered pointers.
  always_comb begin
    occ     = wptr_q - rptr_q;
    empty   = (occ == '0);
    full    = (occ == PW'(DEPTH));
    push    = q.wr_valid_i && !full && !q.flush_i;
    pop     = !empty && q.rd_ready_i && !q.flush_i;
    // A push while full is an overflow even if a pop frees a slot this cycle.
    ovf_set = q.wr_valid_i && full;
  end

  // Next-state for pointers and the sticky overflow flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (q.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (q.overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  // Pointer and flag state.
  always_ff @(posedge hclk_i or negedge hreset_n_i) begin
    if (!hreset_n_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents need no reset since reads are gated by empty.
  always_ff @(posedge hclk_i) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= q.wr_data_i;
    end
  end

  // Drive the consumer and status outputs.
  always_comb begin
    q.wr_ready_o  = !full;
    q.rd_valid_o  = !empty;
    q.rd_data_o   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    q.occupancy_o = OW'(occ);
    q.empty_o     = empty;
    q.full_o      = full;
    q.overflow_o  = overflow_q;
  end

  i3c_hci_queue_thld #(
    .DEPTH      (DEPTH),
    .THLD_WIDTH (THLD_WIDTH),
    .OCC_SENSE  (1'b0)
  ) u_thld (
    .occupancy_i (OW'(occ)),
    .thld_i      (q.thld_i),
    .trig_o      (q.thld_trig_o)
  );

endmodule

// File: tb/tb_i3c_hci_queue.sv
// Directed bench for i3c_hci_queue with a queue-based reference model.
module tb_i3c_hci_queue;

  localparam int unsigned DEPTH = 64;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   checks;
  int   errors;

  logic [31:0] model_q[$];
  logic        model_ovf;

  i3c_hci_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(32), .THLD_WIDTH(8)) qif ();

  i3c_hci_queue #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (32),
    .THLD_WIDTH (8)
  ) dut (
    .hclk_i     (clk),
    .hreset_n_i (rst_n),
    .q          (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: FIFO semantics applied at each clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      automatic int  n       = model_q.size();
      automatic bit  is_full = (n == DEPTH);
      if (qif.flush_i) begin
        model_q.delete();
      end else begin
        if (n > 0 && qif.rd_ready_i) void'(model_q.pop_front());
        if (qif.wr_valid_i && !is_full) model_q.push_back(qif.wr_data_i);
      end
      if (qif.wr_valid_i && is_full) model_ovf = 1'b1;
      else if (qif.overflow_clr_i) model_ovf = 1'b0;
    end
  end

  // Compare process: every mid-cycle while out of reset.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      automatic int unsigned n   = model_q.size();
      automatic int unsigned t   = qif.thld_i;
      automatic int unsigned eff = (t == 0) ? 1 : ((t > DEPTH) ? DEPTH : t);
      chk("model.occupancy", 32'(qif.occupancy_o), n);
      chk("model.empty",     32'(qif.empty_o),     32'(n == 0));
      chk("model.full",      32'(qif.full_o),      32'(n == DEPTH));
      chk("model.wr_ready",  32'(qif.wr_ready_o),  32'(n != DEPTH));
      chk("model.rd_valid",  32'(qif.rd_valid_o),  32'(n != 0));
      chk("model.rd_data",   qif.rd_data_o,        (n != 0) ? model_q[0] : 32'h0);
      chk("model.overflow",  32'(qif.overflow_o),  32'(model_ovf));
      chk("model.thld_trig", 32'(qif.thld_trig_o), 32'((DEPTH - n) >= eff));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      qif.wr_valid_i = 1'b1;
      qif.wr_data_i  = base + 32'(i);
      tick();
    end
    qif.wr_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    qif.flush_i = 1'b1;
    tick();
    qif.flush_i = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag, input logic trig_exp);
    chk({tag, ".occupancy"}, 32'(qif.occupancy_o), 32'd0);
    chk({tag, ".empty"},     32'(qif.empty_o),     32'd1);
    chk({tag, ".full"},      32'(qif.full_o),      32'd0);
    chk({tag, ".wr_ready"},  32'(qif.wr_ready_o),  32'd1);
    chk({tag, ".rd_valid"},  32'(qif.rd_valid_o),  32'd0);
    chk({tag, ".rd_data"},   qif.rd_data_o,        32'd0);
    chk({tag, ".overflow"},  32'(qif.overflow_o),  32'd0);
    chk({tag, ".thld_trig"}, 32'(qif.thld_trig_o), 32'(trig_exp));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    qif.wr_valid_i     = 1'b0;
    qif.wr_data_i      = '0;
    qif.rd_ready_i     = 1'b0;
    qif.thld_i         = 8'd4;
    qif.overflow_clr_i = 1'b0;
    qif.flush_i        = 1'b0;

    // Reset and idle.
    #3;
    chk_reset_values("reset", 1'b1);
    #9;
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk_reset_values("idle", 1'b1);

    // Fill to full, then drain in order.
    qif.thld_i = 8'd1;
    push_n(64, 32'hA5A5_0001);
    chk("fill.full",      32'(qif.full_o),      32'd1);
    chk("fill.wr_ready",  32'(qif.wr_ready_o),  32'd0);
    chk("fill.occupancy", 32'(qif.occupancy_o), 32'd64);
    chk("fill.thld_trig", 32'(qif.thld_trig_o), 32'd0);
    qif.rd_ready_i = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      chk("drain.data", qif.rd_data_o, 32'hA5A5_0000 + 32'(i));
      tick();
    end
    qif.rd_ready_i = 1'b0;
    chk("drain.empty", 32'(qif.empty_o), 32'd1);

    // Push while full with a simultaneous pop: push dropped, overflow set.
    push_n(64, 32'h0000_1000);
    qif.wr_valid_i = 1'b1;
    qif.wr_data_i  = 32'hDEAD_BEEF;
    qif.rd_ready_i = 1'b1;
    chk("ovf.pop_head", qif.rd_data_o, 32'h0000_1000);
    tick();
    qif.wr_valid_i = 1'b0;
    qif.rd_ready_i = 1'b0;
    chk("ovf.overflow",  32'(qif.overflow_o),  32'd1);
    chk("ovf.occupancy", 32'(qif.occupancy_o), 32'd63);
    chk("ovf.new_head",  qif.rd_data_o,        32'h0000_1001);
    qif.overflow_clr_i = 1'b1;
    tick();
    qif.overflow_clr_i = 1'b0;
    chk("ovf.cleared", 32'(qif.overflow_o), 32'd0);

    // Steady push+pop at occupancy 10 across pointer wrap.
    do_flush();
    push_n(10, 32'h0000_2000);
    qif.rd_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      qif.wr_valid_i = 1'b1;
      qif.wr_data_i  = 32'h0000_3000 + 32'(i);
      tick();
    end
    qif.wr_valid_i = 1'b0;
    qif.rd_ready_i = 1'b0;
    chk("stream.occupancy", 32'(qif.occupancy_o), 32'd10);
    chk("stream.head",      qif.rd_data_o,        32'h0000_30BE);

    // Flush beats a same-cycle push and pop.
    do_flush();
    push_n(5, 32'h0000_4000);
    qif.flush_i    = 1'b1;
    qif.wr_valid_i = 1'b1;
    qif.wr_data_i  = 32'hBAD0_BAD0;
    qif.rd_ready_i = 1'b1;
    tick();
    qif.flush_i    = 1'b0;
    qif.wr_valid_i = 1'b0;
    qif.rd_ready_i = 1'b0;
    chk("flush.occupancy", 32'(qif.occupancy_o), 32'd0);
    chk("flush.empty",     32'(qif.empty_o),     32'd1);
    push_n(1, 32'h0000_5555);
    chk("flush.next_head", qif.rd_data_o,        32'h0000_5555);
    chk("flush.next_occ",  32'(qif.occupancy_o), 32'd1);

    // Threshold sweep at occupancy 60 (4 free).
    do_flush();
    push_n(60, 32'h0000_6000);
    qif.thld_i = 8'd4;   #1; chk("thld.4",   32'(qif.thld_trig_o), 32'd1);
    qif.thld_i = 8'd5;   #1; chk("thld.5",   32'(qif.thld_trig_o), 32'd0);
    qif.thld_i = 8'd0;   #1; chk("thld.0",   32'(qif.thld_trig_o), 32'd1);
    qif.thld_i = 8'd255; #1; chk("thld.255", 32'(qif.thld_trig_o), 32'd0);

    // Push burst that overflows, then asynchronous reset between edges.
    @(negedge clk);
    push_n(6, 32'h0000_7000);
    chk("burst.overflow", 32'(qif.overflow_o), 32'd1);
    qif.wr_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset", 1'b1);
    qif.wr_valid_i = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset.occupancy", 32'(qif.occupancy_o), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i3c_hci_queue.md
Name: i3c_hci_queue

Overview:
- Synchronous FIFO directly downstream of the I3C CSR block. Stores command/TX-data words written by software through CSR queue-port registers.
- Presents them to the controller datapath over a valid/ready interface.
- Provides occupancy, full/empty and threshold status back to the CSR hardware interface, plus a sticky overflow flag and a synchronous flush.

Parameters:
- DEPTH, 64, number of entries; power of two, 2..256.
- DATA_WIDTH, 32, entry width; equals I3CCSR_DATA_WIDTH.
- THLD_WIDTH, 8, width of threshold input.

Ports:
- hclk_i  in  1  clock, shared with AHB/CSR domain.
- hreset_n_i  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  one-cycle push strobe from CSR port-register write.
- wr_data_i  in  DATA_WIDTH  push data.
- wr_ready_o  out  1  high when not full; drives CSR write stall.
- rd_valid_o  out  1  head entry available.
- rd_ready_i  in  1  consumer accepts head.
- rd_data_o  out  DATA_WIDTH  head entry (first-word-fall-through).
- thld_i  in  THLD_WIDTH  space-available threshold from CSR.
- thld_trig_o  out  1  free entries >= effective threshold.
- occupancy_o  out  $clog2(DEPTH+1)  entries stored.
- empty_o  out  1  occupancy == 0.
- full_o  out  1  occupancy == DEPTH.
- overflow_o  out  1  sticky: push attempted while full.
- overflow_clr_i  in  1  clears overflow_o (W1C from CSR).
- flush_i  in  1  synchronous flush.

Behaviour:
- Reset values:
  - rptr, wptr, occupancy = 0.
  - empty_o = 1, full_o = 0, wr_ready_o = 1, rd_valid_o = 0.
  - overflow_o = 0, rd_data_o = 0.
  - thld_trig_o per formula with occupancy 0.
- Storage is a DEPTH x DATA_WIDTH register array. Read and write pointers are $clog2(DEPTH)+1 bits; the MSB disambiguates full from empty. Pointers wrap naturally at 2*DEPTH.
- Push fires when wr_valid_i && !full_o. Data is written at wptr[low] and wptr increments. The new entry is visible on rd_valid_o/rd_data_o the next cycle (1-cycle latency).
- Push while full: data is dropped and overflow_o sets next cycle. This holds even if a pop fires in the same cycle; wr_ready_o already signalled the stall.
- Pop fires when rd_valid_o && rd_ready_i; rptr increments. rd_ready_i while empty has no effect (no underflow state).
- Simultaneous push and pop while not full: both fire, occupancy unchanged.
- rd_data_o is combinational from mem[rptr[low]]. It is 0 when empty, so no X propagates.
- rd_valid_o = !empty_o. Once asserted, rd_data_o is stable until the pop or a flush.
- occupancy_o = wptr - rptr, modulo 2*DEPTH.
- Threshold:
  - eff_thld = (thld_i == 0) ? 1 : min(thld_i, DEPTH).
  - thld_trig_o = (DEPTH - occupancy) >= eff_thld, computed in $clog2(DEPTH+1)+1 bits to avoid truncation.
  - thld_trig_o is combinational from registered state and thld_i.
- Flush:
  - flush_i high sets rptr = wptr = 0 next cycle.
  - A push or pop in the same cycle is discarded.
  - overflow_o is unaffected.
- Overflow clear:
  - overflow_clr_i clears overflow_o next cycle.
  - If a new overflow occurs in the same cycle, set wins.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). Memory contents are not reset and are not observable.
- Elaboration checks:
  - DEPTH must be a power of two in 2..256; violation gives $error.
  - THLD_WIDTH >= $clog2(DEPTH+1) is not required because eff_thld clamps.

Decomposition:
- Shared package i3c_hci_pkg:
  - typedef hci_queue_entry_t (logic [DATA_WIDTH-1:0]).
  - constants CMD_QUEUE_DEPTH = 64, TX_QUEUE_DEPTH = 64.
  - function for occupancy width.
- One sub-module: i3c_hci_queue_thld, the combinational threshold clamp/compare. It is reused later for RX/response queues with an inverted (occupancy >= thld) sense via a parameter.

Test Plan:
- Reset, then idle: empty_o=1, wr_ready_o=1, rd_valid_o=0, occupancy_o=0, thld_trig_o=1 with thld_i=4.
- Push 0xA5A5_0001..0xA5A5_0040 (64 words), rd_ready_i=0: full_o=1, wr_ready_o=0, occupancy_o=64, thld_trig_o=0 (thld_i=1). Then pop all: data returned in order, empty_o=1.
- Full FIFO, push 0xDEAD_BEEF with a simultaneous pop: pop returns the head, push is dropped, overflow_o=1, occupancy_o=63. Then assert overflow_clr_i: overflow_o=0 next cycle.
- Occupancy 10, push and pop in the same cycle for 200 cycles across pointer wrap: occupancy_o stays 10, data order is preserved, no spurious full/empty.
- Occupancy 5, flush_i with wr_valid_i=1 and rd_ready_i=1 the same cycle: next cycle occupancy_o=0, empty_o=1, pushed word absent.
- Threshold sweep, occupancy 60, DEPTH=64: thld_i=4 gives trig=1, thld_i=5 gives trig=0, thld_i=0 gives trig=1, thld_i=255 clamps to 64 and gives trig=0. Assert hreset_n_i mid-push burst: all outputs return to reset values without a clock edge.
